// File: rtl/aes_cipher_core.sv
// AES-128 encryption core. AddRoundKey and SubBytes work on one 32-bit column
// per cycle; ShiftRows plus MixColumns transform the full 128-bit state in one cycle.
module aes_cipher_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic        key_ready,
  output logic [3:0]  round_key_num,
  output logic [1:0]  r_index,
  input  logic [31:0] round_key,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_KEY,
    ARK0,
    SUB,
    MIX,
    ARK,
    OUT
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t        fsm;
  logic [3:0]  rnd;
  logic [1:0]  w;
  logic [31:0] blk     [4];
  logic [31:0] shifted [4];
  logic [31:0] mixed   [4];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r of the state rotates left by r columns; the last round leaves out MixColumns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      shifted[c] = {blk[c][31:24],
                    blk[2'(c + 1)][23:16],
                    blk[2'(c + 2)][15:8],
                    blk[2'(c + 3)][7:0]};
      mixed[c]   = (rnd == 4'd10) ? shifted[c] : mix_column(shifted[c]);
    end
  end

  assign round_key_num = rnd;
  assign r_index       = w;
  assign busy          = (fsm != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      w         <= 2'd0;
      out_valid <= 1'b0;
      data_out  <= 32'h0;
      for (int i = 0; i < 4; i++) blk[i] <= 32'h0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            blk[0] <= data_in;
            w      <= 2'd1;
            fsm    <= LOAD;
          end
        end
        LOAD: begin
          if (start) begin
            blk[w] <= data_in;
            w      <= w + 2'd1;
            if (w == 2'd3) fsm <= WAIT_KEY;
          end else begin
            w   <= 2'd0;
            fsm <= IDLE;
          end
        end
        WAIT_KEY: begin
          if (key_ready) begin
            rnd <= 4'd0;
            w   <= 2'd0;
            fsm <= ARK0;
          end
        end
        ARK0: begin
          if (key_ready) begin
            blk[w] <= blk[w] ^ round_key;
            w      <= w + 2'd1;
            if (w == 2'd3) begin
              rnd <= 4'd1;
              fsm <= SUB;
            end
          end
        end
        SUB: begin
          if (key_ready) begin
            blk[w] <= sub_word(blk[w]);
            w      <= w + 2'd1;
            if (w == 2'd3) fsm <= MIX;
          end
        end
        MIX: begin
          if (key_ready) begin
            for (int c = 0; c < 4; c++) blk[c] <= mixed[c];
            fsm <= ARK;
          end
        end
        ARK: begin
          if (key_ready) begin
            blk[w] <= blk[w] ^ round_key;
            w      <= w + 2'd1;
            // Column 0 is already final when the last word of round 10 is keyed.
            if (w == 2'd3) begin
              if (rnd == 4'd10) begin
                out_valid <= 1'b1;
                data_out  <= blk[0];
                fsm       <= OUT;
              end else begin
                rnd <= rnd + 4'd1;
                fsm <= SUB;
              end
            end
          end
        end
        OUT: begin
          w <= w + 2'd1;
          if (w == 2'd3) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end else begin
            data_out <= blk[w + 2'd1];
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
